// File: rtl/inst_sram_like_slave_pkg.sv
// Shared types and constants for the SRAM-like instruction-fetch responder.
// Holds the fetch request record, the FSM encoding and the legality rule.
package inst_sram_like_slave_pkg;

   localparam logic        RST_ENABLE  = 1'b1;
   localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
   localparam int          INST_ADDR_W = 32;
   localparam int          INST_W      = 32;
   localparam logic [1:0]  SIZE_WORD   = 2'b10;

   typedef enum logic [1:0] {
      IFS_IDLE  = 2'd0,
      IFS_WAIT  = 2'd1,
      IFS_ISSUE = 2'd2,
      IFS_RESP  = 2'd3
   } ifs_state_t;

   typedef struct packed {
      logic [INST_ADDR_W-1:0] addr;
      logic                   wr;
      logic [1:0]             size;
   } fetch_req_t;

   // Only aligned word reads reach the RAM; everything else answers with err.
   function automatic logic is_legal(fetch_req_t r);
      return !r.wr && (r.size == SIZE_WORD) && (r.addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/inst_sram_like_slave_if.sv
// Fetch-side SRAM-like bus between the PC/fetch stage (master) and this responder (slave).
interface inst_sram_like_slave_if;
   import inst_sram_like_slave_pkg::*;

   logic                   req;
   logic                   wr;
   logic [1:0]             size;
   logic [INST_ADDR_W-1:0] addr;
   logic                   addr_ok;
   logic [INST_W-1:0]      rdata;
   logic                   data_ok;
   logic                   err;

   // A request transfers on every rising edge with req && addr_ok; addr_ok never looks
   // at req. data_ok is a one-cycle pulse per accepted request, in order, with no stall.
   modport master (output req, wr, size, addr, input addr_ok, rdata, data_ok, err);
   modport slave  (input req, wr, size, addr, output addr_ok, rdata, data_ok, err);

endinterface

// File: rtl/inst_sram_like_slave_sync_fifo.sv
// In-order request queue: register array with wrap-around pointers and an occupancy count.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_sram_like_slave.sv
// SRAM-like instruction-fetch responder: queues fetch addresses and reads a
// single-port synchronous instruction RAM, answering strictly in request order.
module inst_sram_like_slave
   import inst_sram_like_slave_pkg::*;
#(
   parameter int RAM_AW          = 14,
   parameter int WAIT_CYCLES     = 0,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   inst_sram_like_slave_if.slave      bus,
   output logic                       ram_en,
   output logic [RAM_AW-1:0]          ram_addr,
   input  logic [INST_W-1:0]          ram_rdata,
   output logic                       busy,
   output ifs_state_t                 dbg_state
);

   localparam int         CW        = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

   fetch_req_t      push_req;
   fetch_req_t      head;
   logic [CW-1:0]   count;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;
   logic            head_legal;
   ifs_state_t      state;
   logic [2:0]      wait_cnt;
   logic            data_ok_q;
   logic            err_q;

   assign push_req    = fetch_req_t'{addr: bus.addr, wr: bus.wr, size: bus.size};
   assign bus.addr_ok = (rst != RST_ENABLE) && !full;
   assign push        = bus.req && bus.addr_ok;
   assign pop         = (state == IFS_ISSUE);

   sync_fifo #(
      .WIDTH ($bits(fetch_req_t)),
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_req),
      .dout  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   assign head_legal  = is_legal(head);
   assign ram_en      = (state == IFS_ISSUE) && head_legal;
   assign ram_addr    = ram_en ? head.addr[RAM_AW+1:2] : '0;
   assign bus.data_ok = data_ok_q;
   assign bus.err     = err_q;
   assign bus.rdata   = (data_ok_q && !err_q) ? ram_rdata : ZERO_WORD;
   assign busy        = (count != '0) || (state != IFS_IDLE);
   assign dbg_state   = state;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state     <= IFS_IDLE;
         wait_cnt  <= 3'd0;
         data_ok_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         data_ok_q <= (state == IFS_ISSUE);
         err_q     <= (state == IFS_ISSUE) && !head_legal;
         case (state)
            // Leaving IDLE on the accepting edge itself gives ram_en one cycle after the handshake.
            IFS_IDLE: begin
               if (!empty || push) begin
                  if (WAIT_CYCLES > 0) begin
                     state    <= IFS_WAIT;
                     wait_cnt <= WAIT_INIT;
                  end else begin
                     state <= IFS_ISSUE;
                  end
               end
            end
            IFS_WAIT: begin
               if (wait_cnt == 3'd0) state <= IFS_ISSUE;
               else                  wait_cnt <= wait_cnt - 3'd1;
            end
            IFS_ISSUE: state <= IFS_RESP;
            IFS_RESP: begin
               if (!empty) begin
                  if (WAIT_CYCLES > 0) begin
                     state    <= IFS_WAIT;
                     wait_cnt <= WAIT_INIT;
                  end else begin
                     state <= IFS_ISSUE;
                  end
               end else begin
                  state <= IFS_IDLE;
               end
            end
            default: state <= IFS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_sram_like_slave.sv
// Bench for the SRAM-like fetch responder: a zero-wait and a three-wait instance against a RAM model.
module tb_inst_sram_like_slave;
   import inst_sram_like_slave_pkg::*;

   localparam int RAM_AW    = 14;
   localparam int RAM_WORDS = 1 << RAM_AW;

   logic clk  = 1'b0;
   logic rst0 = 1'b1;
   logic rst3 = 1'b1;
   always #5 clk = ~clk;

   inst_sram_like_slave_if bus0 ();
   inst_sram_like_slave_if bus3 ();

   logic              ram_en0, ram_en3;
   logic [RAM_AW-1:0] ram_addr0, ram_addr3;
   logic [31:0]       ram_rdata0, ram_rdata3;
   logic              busy0, busy3;
   ifs_state_t        st0, st3;

   logic [31:0] mem [RAM_WORDS];

   inst_sram_like_slave #(.RAM_AW(RAM_AW), .WAIT_CYCLES(0), .MAX_OUTSTANDING(2)) u_dut0 (
      .clk(clk), .rst(rst0), .bus(bus0), .ram_en(ram_en0), .ram_addr(ram_addr0),
      .ram_rdata(ram_rdata0), .busy(busy0), .dbg_state(st0));

   inst_sram_like_slave #(.RAM_AW(RAM_AW), .WAIT_CYCLES(3), .MAX_OUTSTANDING(2)) u_dut3 (
      .clk(clk), .rst(rst3), .bus(bus3), .ram_en(ram_en3), .ram_addr(ram_addr3),
      .ram_rdata(ram_rdata3), .busy(busy3), .dbg_state(st3));

   // Synchronous single-port RAM: data appears the cycle after the enable.
   always @(posedge clk) begin
      if (ram_en0) ram_rdata0 <= mem[ram_addr0];
      if (ram_en3) ram_rdata3 <= mem[ram_addr3];
   end

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_resp0 = 0;
   int n_resp3 = 0;
   logic [32:0]       exp_q[$];
   logic [32:0]       exp3_q[$];
   logic [RAM_AW-1:0] iss_q[$];

   // Reference: legal aligned word reads return the aliased RAM word, anything else err with 0.
   function automatic logic [32:0] model(logic [31:0] a, logic w, logic [1:0] s);
      if (w || s != 2'b10 || (a % 4) != 0) return {1'b1, 32'h0};
      return {1'b0, mem[(a / 4) % RAM_WORDS]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: pop an expectation for every data_ok, and an expected RAM word for every ram_en.
   always @(negedge clk) begin
      if (!rst0) begin
         if (bus0.data_ok) begin
            n_resp0++;
            if (exp_q.size() == 0) check("dut0_unexpected_data_ok", bus0.data_ok, 0);
            else                   check("dut0_resp", {bus0.err, bus0.rdata}, exp_q.pop_front());
         end else begin
            check("dut0_quiet_outputs", {bus0.err, bus0.rdata}, 0);
         end
         if (ram_en0) begin
            if (iss_q.size() == 0) check("dut0_unexpected_ram_en", ram_en0, 0);
            else                   check("dut0_ram_addr", ram_addr0, iss_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst3 && bus3.data_ok) begin
         n_resp3++;
         if (exp3_q.size() == 0) check("dut3_unexpected_data_ok", bus3.data_ok, 0);
         else                    check("dut3_resp", {bus3.err, bus3.rdata}, exp3_q.pop_front());
      end
   end

   // Drivers start and end at 1 time unit after a rising edge.
   task automatic send0(input logic [31:0] a, input logic w, input logic [1:0] s, output int waited);
      logic [32:0] e;
      waited = 0;
      bus0.req = 1'b1; bus0.addr = a; bus0.wr = w; bus0.size = s;
      @(negedge clk);
      while (!bus0.addr_ok && waited < 40) begin @(negedge clk); waited++; end
      check("dut0_accept", bus0.addr_ok, 1);
      if (bus0.addr_ok) begin
         e = model(a, w, s);
         exp_q.push_back(e);
         if (!e[32]) iss_q.push_back(RAM_AW'((a / 4) % RAM_WORDS));
      end
      @(posedge clk); #1;
      bus0.req = 1'b0;
   endtask

   task automatic send3(input logic [31:0] a, input logic w, input logic [1:0] s);
      int waited = 0;
      bus3.req = 1'b1; bus3.addr = a; bus3.wr = w; bus3.size = s;
      @(negedge clk);
      while (!bus3.addr_ok && waited < 40) begin @(negedge clk); waited++; end
      check("dut3_accept", bus3.addr_ok, 1);
      if (bus3.addr_ok) exp3_q.push_back(model(a, w, s));
      @(posedge clk); #1;
      bus3.req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain0();
      int g = 0;
      while ((exp_q.size() != 0 || iss_q.size() != 0 || busy0) && g < 200) begin idle(1); g++; end
      check("dut0_drain", g < 200, 1);
   endtask

   task automatic drain3();
      int g = 0;
      while ((exp3_q.size() != 0 || busy3) && g < 200) begin idle(1); g++; end
      check("dut3_drain", g < 200, 1);
   endtask

   task automatic pulse_reset0();
      rst0 = 1'b1;
      exp_q.delete();
      iss_q.delete();
      idle(1);
      rst0 = 1'b0;
   endtask

   task automatic pulse_reset3();
      rst3 = 1'b1;
      exp3_q.delete();
      idle(1);
      rst3 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      int          sum_w;
      int          base;
      int          lat;
      int          kind;
      logic [31:0] a;
      logic        wr_r;
      logic [1:0]  sz;

      for (int i = 0; i < RAM_WORDS; i++) mem[i] = $urandom;
      mem[0] = 32'h3c08bfc0;
      bus0.req = 1'b0; bus0.addr = '0; bus0.wr = 1'b0; bus0.size = 2'b10;
      bus3.req = 1'b0; bus3.addr = '0; bus3.wr = 1'b0; bus3.size = 2'b10;

      // Reset state
      @(negedge clk);
      check("dut0_addr_ok_in_reset", bus0.addr_ok, 0);
      check("dut3_addr_ok_in_reset", bus3.addr_ok, 0);
      idle(3);
      rst0 = 1'b0;
      rst3 = 1'b0;
      @(negedge clk);
      check("reset_addr_ok", bus0.addr_ok, 1);
      check("reset_data_ok", {bus0.data_ok, bus0.err}, 0);
      check("reset_ram", {ram_en0, ram_addr0}, 0);
      check("reset_busy", busy0, 0);
      check("reset_state", st0, IFS_IDLE);
      idle(1);

      // Single read through an aliased boot address
      send0(32'hbfc00000, 1'b0, 2'b10, w);
      check("single_addr_ok_same_cycle", w, 0);
      @(negedge clk);
      check("single_ram_en", {ram_en0, ram_addr0}, {1'b1, RAM_AW'(0)});
      @(negedge clk);
      check("single_data_ok", {bus0.data_ok, bus0.err, bus0.rdata}, {2'b10, 32'h3c08bfc0});
      idle(1);
      drain0();

      // Back-to-back with backpressure
      base = n_resp0;
      sum_w = 0;
      for (int i = 0; i < 4; i++) begin
         send0(32'(i * 4), 1'b0, 2'b10, w);
         sum_w += w;
      end
      drain0();
      check("b2b_backpressure_seen", sum_w > 0, 1);
      check("b2b_response_count", n_resp0 - base, 4);

      // Illegal requests
      base = n_resp0;
      send0(32'h2, 1'b0, 2'b10, w);
      send0(32'h4, 1'b1, 2'b10, w);
      send0(32'h8, 1'b0, 2'b00, w);
      drain0();
      check("illegal_response_count", n_resp0 - base, 3);

      // Push in the pop cycle
      base = n_resp0;
      send0(32'h40, 1'b0, 2'b10, w);
      send0(32'h44, 1'b0, 2'b10, w);
      drain0();
      check("push_pop_response_count", n_resp0 - base, 2);

      // Randomized traffic with a reset in the middle
      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 9);
         a    = $urandom;
         wr_r = 1'b0;
         sz   = 2'b10;
         if (kind < 7)       a[1:0] = 2'b00;
         else if (kind == 7) a[1:0] = 2'($urandom_range(1, 3));
         else if (kind == 8) begin a[1:0] = 2'b00; wr_r = 1'b1; end
         else begin
            a[1:0] = 2'b00;
            sz = 2'($urandom_range(0, 2));
            if (sz == 2'b10) sz = 2'b11;
         end
         send0(a, wr_r, sz, w);
         if (i == 75) begin
            pulse_reset0();
            @(negedge clk);
            check("dut0_busy_after_reset", {busy0, ram_en0}, 0);
            idle(1);
         end
         kind = $urandom_range(0, 2);
         if (kind != 0) idle(kind);
      end
      drain0();

      // Wait states: handshake-to-data_ok latency
      send3(32'h8000_0100, 1'b0, 2'b10);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus3.data_ok && lat < 30);
      check("dut3_latency", lat, 5);
      idle(1);
      drain3();

      // Full queue: addr_ok low from the cycle after the filling push until after the pop
      send3(32'h10, 1'b0, 2'b10);
      send3(32'h14, 1'b0, 2'b10);
      lat = 0;
      @(negedge clk);
      while (!bus3.addr_ok && lat < 30) begin lat++; @(negedge clk); end
      check("dut3_full_low_cycles", lat, 3);
      idle(1);
      drain3();

      // Reset with two requests queued
      send3(32'h20, 1'b0, 2'b10);
      send3(32'h24, 1'b0, 2'b10);
      pulse_reset3();
      @(negedge clk);
      check("dut3_after_reset", {busy3, ram_en3, bus3.data_ok}, 0);
      idle(12);
      send3(32'h28, 1'b0, 2'b10);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!bus3.data_ok && lat < 30);
      check("dut3_latency_after_reset", lat, 5);
      idle(1);
      drain3();

      // Random traffic on the waited instance
      base = n_resp3;
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         a[1:0] = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b00;
         send3(a, 1'b0, 2'b10);
      end
      drain3();
      check("dut3_random_response_count", n_resp3 - base, 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/inst_sram_like_slave.md
# inst_sram_like_slave

Responder end of the SRAM-like instruction-fetch interface driven by the PC/fetch stage. It accepts fetch addresses with `addr_ok`, queues up to `MAX_OUTSTANDING` of them, and reads a single-port synchronous instruction RAM. It returns each instruction word in request order with a one-cycle `data_ok` pulse. It sits between the fetch stage and the on-chip instruction RAM, and serves as the memory model for CPU-level benches.

## Interface
- `RAM_AW`, default 14: word-address width of the instruction RAM (64 KiB).
- `WAIT_CYCLES`, default 0: extra idle cycles inserted before every RAM access, legal range 0..7.
- `MAX_OUTSTANDING`, default 2: depth of the request queue, power of two, 2..8.
- `clk` in, 1 bit: single clock; everything is sampled on the rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `req` in, 1 bit: request valid from the fetch stage.
- `wr` in, 1 bit: write request; not supported, see Operation.
- `size` in, 2 bits: transfer size; only 2'b10 (word) is legal.
- `addr` in, 32 bits (`InstAddrBus`): byte address.
- `addr_ok` out, 1 bit: request accepted this cycle when `req` is also high.
- `rdata` out, 32 bits: instruction word, valid only while `data_ok` is high.
- `data_ok` out, 1 bit: one-cycle response pulse, one per accepted request.
- `err` out, 1 bit: qualifies `data_ok`; the response is an error and `rdata` is 0.
- `ram_en` out, 1 bit: RAM read enable.
- `ram_addr` out, `RAM_AW` bits: RAM word address.
- `ram_rdata` in, 32 bits: RAM read data, valid the cycle after `ram_en`.
- `busy` out, 1 bit: queue non-empty or an access is in flight.

## Operation
- **Handshake.**
  - A request is accepted in any cycle with `req && addr_ok`.
  - `addr_ok = !rst && (count < MAX_OUTSTANDING)`; it is combinational and does not depend on `req`.
  - The fetch stage may change `addr` freely while `addr_ok` is low.
- **Queue.**
  - Each accepted request pushes `{addr, wr, size}` into an in-order FIFO.
  - A push and a pop in the same cycle leave `count` unchanged.
- **FSM states.** IDLE, WAIT, ISSUE, RESP.
  - IDLE: if the queue is non-empty, go to WAIT when `WAIT_CYCLES > 0`, otherwise go to ISSUE.
  - WAIT: a counter loads `WAIT_CYCLES-1` and decrements; at 0 go to ISSUE.
  - ISSUE: pop the queue head. For a legal head, assert `ram_en` and drive `ram_addr = addr[RAM_AW+1:2]`. Then go to RESP.
  - RESP:
    - Assert `data_ok` with `rdata = ram_rdata`.
    - If the queue is non-empty and `WAIT_CYCLES == 0`, go directly to ISSUE; the pending pop happens in that ISSUE cycle.
    - Otherwise, if the queue is non-empty, go to WAIT.
    - If the queue is empty, go to IDLE.
- **Illegal requests.** A request is illegal if `wr=1`, `size != 2'b10`, or `addr[1:0] != 0`.
  - It is still accepted and consumes one queue slot and one ISSUE/RESP pass.
  - `ram_en` stays 0 in its ISSUE cycle.
  - In RESP it gives `data_ok=1`, `err=1`, `rdata=0`.
- **Address range.** `addr[31:RAM_AW+2]` is ignored; addresses alias modulo the RAM size. Example: 0xbfc00000 maps to word 0 when `RAM_AW=14`.
- **Ordering.** Responses are strictly in acceptance order, and every accepted request gets exactly one `data_ok`.
- **Flush.** This block has no flush input. The requester discards responses it no longer wants.

## Timing
- **Reset.**
  - While `rst` is high, `addr_ok` is 0.
  - After a `rst` edge, all registers are cleared: queue empty, FSM IDLE, wait counter 0, `data_ok=0`, `err=0`, `ram_en=0`, `ram_addr=0`, `busy=0`.
  - `rdata` is 0 whenever `data_ok` is 0.
- **Latency.** For a handshake in cycle T with an idle block:
  - `ram_en` is high in T+1+`WAIT_CYCLES`.
  - `data_ok` is high in T+2+`WAIT_CYCLES`.
- **Throughput.** With `WAIT_CYCLES=0` and a continuously non-empty queue, ISSUE and RESP alternate, giving one response every 2 cycles.
- **Full queue.** `addr_ok` falls in the cycle after the push that fills the queue. It rises in the cycle after the pop.
- **Reset mid-operation.** Queued and in-flight requests are dropped with no `data_ok`. `ram_en` is 0 in the cycle after `rst` is sampled.

## Structure
- **`defines.v`.** Holds `RstEnable`, `ZeroWord`, `Ready`, `InstAddrBus`, `InstBus`, and new FSM state encodings `IfsIdle`, `IfsWait`, `IfsIssue`, `IfsResp` (2 bits).
- **`sync_fifo` sub-module.** Parameters are `WIDTH` and `DEPTH`, with ports push, pop, din, dout, count, empty, full. It is a register array with wrap-around read/write pointers of `$clog2(DEPTH)` bits plus a count of `$clog2(DEPTH)+1` bits, and it is synchronously reset. Pushing when full and popping when empty are both blocked inside the FIFO.

## Test plan
- **Single read.** Preload RAM word 0 = 0x3c08bfc0, `WAIT_CYCLES=0`; `req=1`, `addr=0xbfc00000` in T → `addr_ok=1` in T, `ram_en=1` with `ram_addr=0` in T+1, `data_ok=1` with `rdata=0x3c08bfc0` and `err=0` in T+2.
- **Back-to-back and backpressure.** Hold `req` with addresses 0x0, 0x4, 0x8, 0xc → exactly 4 `data_ok` pulses in order with the matching words; `addr_ok` drops to 0 once 2 requests are outstanding.
- **Wait states.** `WAIT_CYCLES=3` → handshake-to-`data_ok` latency is 5 cycles.
- **Illegal requests.** `addr=0x2`, then `wr=1`, then `size=0` → 3 responses, each with `err=1`, `rdata=0`, and `ram_en` never asserted for them.
- **Reset mid-operation.** Assert `rst` for 1 cycle with 2 requests queued → no `data_ok` afterwards, `busy=0`, and a new request afterwards completes normally.
- **Simultaneous push and pop.** Push in the same cycle as a pop with `count=1` → count stays 1 and no request is lost or duplicated.
